// File: rtl/tablero_pkg.sv
// Shared types and constants for the random token inserter: cell values,
// controller states and the LFSR feedback taps.
package tablero_pkg;

    // Contents of one board cell
    typedef enum logic [1:0] {
        VACIO = 2'b00,
        J1    = 2'b01,
        J2    = 2'b10
    } celda_t;

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSCAR   = 2'b01,
        INSERTAR = 2'b10
    } estado_t;

    // Taps of x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register
    // (bits 7, 5, 4 and 3 feed the new LSB)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; loads the seed while reset is asserted.
module lfsr8
    import tablero_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] semilla,
    output logic [7:0] q
);

    // Shift left every cycle, feeding back the XOR of the tapped bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= semilla;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/insertor_aleatorio.sv
// Drops one token into a connect-four style board. The start column comes
// from the LFSR or from col_in; columns are probed left to right (wrapping)
// until one with a free top cell is found, then the token falls to the
// lowest free row of that column.
module insertor_aleatorio
    import tablero_pkg::*;
#(
    parameter int         FILAS    = 6,
    parameter int         COLUMNAS = 7,
    parameter logic [7:0] SEMILLA  = 8'hA5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        modo,
    input  logic [3:0]                  col_in,
    input  logic [1:0]                  jugador,
    input  logic [2*FILAS*COLUMNAS-1:0] tablero_in,
    output logic [2*FILAS*COLUMNAS-1:0] tablero_out,
    output logic                        busy,
    output logic                        done,
    output logic                        lleno,
    output logic                        err_jugador,
    output logic [2:0]                  fila_out,
    output logic [3:0]                  col_out
);

    localparam int         ANCHO      = 2 * FILAS * COLUMNAS;
    localparam logic [3:0] COL_ULTIMA = 4'(COLUMNAS - 1);

    // Cell (fila, col) of a flattened board; row-major, two bits per cell
    function automatic logic [1:0] celda(input logic [ANCHO-1:0] t,
                                         input int fila, input int col);
        return t[(fila * COLUMNAS + col) * 2 +: 2];
    endfunction

    estado_t    estado, estado_sig;
    logic [7:0] lfsr;
    logic [3:0] col;
    logic [3:0] sondeos;
    logic [3:0] col_ini;
    logic [1:0] jugador_q;
    logic       err_pend;
    logic       acepta;
    logic       jugador_ok;
    logic       col_libre;
    logic [2:0] fila_libre;

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .semilla (SEMILLA),
        .q       (lfsr)
    );

    // Start column selection and request admission. A pending illegal-player
    // report blocks a new start for its single cycle so the two never collide.
    always_comb begin
        int base;
        base       = modo ? int'(col_in) : int'(lfsr);
        col_ini    = 4'(base % COLUMNAS);
        jugador_ok = (jugador == J1) || (jugador == J2);
        acepta     = (estado == IDLE) && start && !err_pend;
    end

    // Top-cell test and lowest free row of the column under probe
    always_comb begin
        col_libre  = (celda(tablero_out, 0, int'(col)) == VACIO);
        fila_libre = '0;
        for (int r = 0; r < FILAS; r++) begin
            if (celda(tablero_out, r, int'(col)) == VACIO) begin
                fila_libre = 3'(r);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE: begin
                if (acepta && jugador_ok) begin
                    estado_sig = BUSCAR;
                end
            end
            BUSCAR: begin
                if (col_libre) begin
                    estado_sig = INSERTAR;
                end else if (sondeos == COL_ULTIMA) begin
                    estado_sig = IDLE;
                end
            end
            INSERTAR: estado_sig = IDLE;
            default:  estado_sig = IDLE;
        endcase
    end

    // Board, probe bookkeeping and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tablero_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lleno       <= 1'b0;
            err_jugador <= 1'b0;
            fila_out    <= '0;
            col_out     <= '0;
            col         <= '0;
            sondeos     <= '0;
            jugador_q   <= '0;
            err_pend    <= 1'b0;
        end else begin
            done        <= 1'b0;
            lleno       <= 1'b0;
            err_jugador <= 1'b0;
            err_pend    <= 1'b0;
            if (err_pend) begin
                done        <= 1'b1;
                err_jugador <= 1'b1;
            end
            case (estado)
                IDLE: begin
                    if (acepta) begin
                        if (jugador_ok) begin
                            tablero_out <= tablero_in;
                            jugador_q   <= jugador;
                            col         <= col_ini;
                            sondeos     <= '0;
                            busy        <= 1'b1;
                        end else begin
                            err_pend <= 1'b1;
                        end
                    end
                end
                BUSCAR: begin
                    if (!col_libre) begin
                        if (sondeos == COL_ULTIMA) begin
                            done  <= 1'b1;
                            lleno <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            col     <= (col == COL_ULTIMA) ? 4'd0 : col + 4'd1;
                            sondeos <= sondeos + 4'd1;
                        end
                    end
                end
                INSERTAR: begin
                    tablero_out[(int'(fila_libre) * COLUMNAS + int'(col)) * 2 +: 2] <= jugador_q;
                    fila_out <= fila_libre;
                    col_out  <= col;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insertor_aleatorio.sv
// Randomized self-checking bench for insertor_aleatorio with a
// behavioural board model.
module tb_insertor_aleatorio;

    localparam int F = 6;
    localparam int C = 7;
    localparam int W = 2 * F * C;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         modo = 1'b0;
    logic [3:0]   col_in = '0;
    logic [1:0]   jugador = 2'b01;
    logic [W-1:0] tablero_in = '0;
    logic [W-1:0] tablero_out;
    logic         busy, done, lleno, err_jugador;
    logic [2:0]   fila_out;
    logic [3:0]   col_out;

    always #5 clk = ~clk;

    insertor_aleatorio #(.FILAS(F), .COLUMNAS(C), .SEMILLA(8'hA5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .modo        (modo),
        .col_in      (col_in),
        .jugador     (jugador),
        .tablero_in  (tablero_in),
        .tablero_out (tablero_out),
        .busy        (busy),
        .done        (done),
        .lleno       (lleno),
        .err_jugador (err_jugador),
        .fila_out    (fila_out),
        .col_out     (col_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference sequence x^8+x^6+x^5+x^4+1, one step per rising edge
    logic [7:0] lfsr_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 8'hA5;
        else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    // Board model: bd[row][col], row 0 on top
    int           bd[F][C];
    logic [W-1:0] exp_out  = '0;
    logic [2:0]   exp_fila = '0;
    logic [3:0]   exp_col  = '0;

    function automatic logic [W-1:0] pack_board();
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < C; c++)
                v[(r * C + c) * 2 +: 2] = 2'(bd[r][c]);
        return v;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < F; r++)
            for (int c = 0; c < C; c++)
                bd[r][c] = 0;
    endtask

    task automatic fill_col(input int c, input int h);
        for (int r = 0; r < F; r++)
            bd[r][c] = (r >= F - h) ? int'($urandom_range(1, 2)) : 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_board"}, tablero_out, exp_out);
        chk({tag, "_fila"}, fila_out, exp_fila);
        chk({tag, "_col"}, col_out, exp_col);
        chk({tag, "_ctl"}, {busy, done, lleno, err_jugador}, 4'b0000);
    endtask

    // One drop; entered and left at a falling edge with the DUT idle
    task automatic run_op(input bit m, input logic [3:0] ci, input logic [1:0] j, input bit noise);
        int c0, lat, fr, fc, n;
        bit full, bad;
        logic [W-1:0] in_v;
        in_v = pack_board();
        c0   = m ? (int'(ci) % C) : (int'(lfsr_m) % C);
        bad  = (j == 2'b00) || (j == 2'b11);
        full = 1'b1; fr = 0; fc = 0; lat = 1;
        if (!bad) begin
            for (int k = 0; k < C; k++) begin
                int cc;
                cc = (c0 + k) % C;
                if (full && bd[0][cc] == 0) begin
                    full = 1'b0;
                    fc   = cc;
                    lat  = k + 2;
                end
            end
            if (full) lat = C;
            else
                for (int r = 0; r < F; r++)
                    if (bd[r][fc] == 0) fr = r;
        end

        tablero_in = in_v; modo = m; col_in = ci; jugador = j; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        if (!bad) chk("busy_after_start", busy, 1'b1);
        n = 0;
        while (!done && n < C + 4) begin
            chk("flags_without_done", {lleno, err_jugador}, 2'b00);
            if (noise && !bad) start = 1'($urandom % 2);
            @(posedge clk); @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", n, lat);
        chk("lleno", lleno, !bad && full);
        chk("err_jugador", err_jugador, bad);
        chk("busy_at_done", busy, 1'b0);
        if (!bad) begin
            exp_out = in_v;
            if (!full) begin
                bd[fr][fc] = int'(j);
                exp_out  = pack_board();
                exp_fila = 3'(fr);
                exp_col  = 4'(fc);
            end
        end
        chk("fila_out", fila_out, exp_fila);
        chk("col_out", col_out, exp_col);
        chk("tablero_out", tablero_out, exp_out);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // Start on the very first edge after reset release, LFSR column
        reset_n = 1'b1;
        run_op(1'b0, 4'd0, 2'b01, 1'b0);
        chk("first_lfsr_col", col_out, 4'd4);

        // Empty board, explicit column 3
        @(negedge clk);
        clear_board();
        run_op(1'b1, 4'd3, 2'b01, 1'b0);
        chk("empty_fila", fila_out, 3'd5);
        chk("empty_col", col_out, 4'd3);
        chk("empty_cell", tablero_out[(5 * C + 3) * 2 +: 2], 2'b01);

        // Columns 3 and 4 full
        clear_board();
        fill_col(3, F); fill_col(4, F);
        run_op(1'b1, 4'd3, 2'b10, 1'b0);
        chk("skip2_fila", fila_out, 3'd5);
        chk("skip2_col", col_out, 4'd5);

        // Full board, LFSR column
        for (int c = 0; c < C; c++) fill_col(c, F);
        run_op(1'b0, 4'd0, 2'b01, 1'b0);
        chk("full_lleno", lleno, 1'b1);
        chk("full_board", tablero_out, tablero_in);

        // Only column 6 row 0 free, start at 9 mod 7 = 2
        for (int c = 0; c < C; c++) fill_col(c, F);
        fill_col(6, F - 1);
        run_op(1'b1, 4'd9, 2'b01, 1'b0);
        chk("wrap_fila", fila_out, 3'd0);
        chk("wrap_col", col_out, 4'd6);

        // Illegal player
        run_op(1'b1, 4'd0, 2'b11, 1'b0);
        chk("illegal_err", err_jugador, 1'b1);
        @(negedge clk);
        chk("illegal_pulse_len", done, 1'b0);

        // Reset in the middle of a search
        for (int c = 0; c < C; c++) fill_col(c, F);
        tablero_in = pack_board(); modo = 1'b1; col_in = 4'd0; jugador = 2'b10; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_out = '0; exp_fila = '0; exp_col = '0;
        check_idle_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_done", done, 1'b0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < C + 2; i++) begin
            @(negedge clk);
            chk("after_abort_no_done", done, 1'b0);
        end

        // Randomized drops on an evolving board, with back-to-back starts
        clear_board();
        for (int i = 0; i < 60; i++) begin
            int gap;
            logic [1:0] j;
            if ($urandom % 8 == 0) begin
                for (int c = 0; c < C; c++) fill_col(c, int'($urandom_range(0, F)));
            end
            if ($urandom % 10 == 0) j = ($urandom % 2) ? 2'b11 : 2'b00;
            else                    j = ($urandom % 2) ? 2'b10 : 2'b01;
            run_op(1'($urandom % 2), 4'($urandom % 16), j, 1'b1);
            gap = int'($urandom % 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("idle_done", {done, lleno, err_jugador}, 3'b000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/insertor_aleatorio.md
INSERTOR_ALEATORIO -- requirements
Module: insertor_aleatorio

Interface
REQ-001 Parameter FILAS, default 6: board rows; row 0 is the top row; legal range 4..8.
REQ-002 Parameter COLUMNAS, default 7: board columns; legal range 4..15.
REQ-003 Parameter SEMILLA, default 8'hA5: LFSR reset value; must be non-zero.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request one token drop; sampled only in IDLE.
REQ-007 modo  in  1  0 = LFSR-chosen start column; 1 = start column taken from col_in.
REQ-008 col_in  in  4  start column for modo=1; values >= COLUMNAS wrap to col_in mod COLUMNAS.
REQ-009 jugador  in  2  token value: 2'b01 or 2'b10.
REQ-010 tablero_in  in  2 x FILAS x COLUMNAS  board snapshot, captured on start.
REQ-011 tablero_out  out  2 x FILAS x COLUMNAS  registered board, including the last insertion.
REQ-012 busy  out  1  high from the edge after start is accepted until the edge that raises done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 lleno  out  1  valid with done: no free column was found.
REQ-015 err_jugador  out  1  valid with done: jugador was illegal.
REQ-016 fila_out  out  3  row written; valid with done when lleno=0 and err_jugador=0.
REQ-017 col_out  out  4  column written; same validity as fila_out.

Function
REQ-018 States SHALL be IDLE, BUSCAR, INSERTAR.
REQ-019 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in every state.
REQ-020 IDLE with start=1 at edge E SHALL:
- copy tablero_in into tablero_out and latch jugador;
- set the current column to lfsr mod COLUMNAS (modo=0) or col_in mod COLUMNAS (modo=1);
- clear the probe counter;
- move to BUSCAR.
REQ-021 If jugador is 2'b00 or 2'b11 at E, the block SHALL skip BUSCAR, stay IDLE, leave the board unchanged, and pulse done with err_jugador=1 at edge E+1.
REQ-022 BUSCAR, each cycle: if tablero_out[0][col] == 2'b00, go to INSERTAR. Otherwise, if probes == COLUMNAS-1, pulse done with lleno=1 and return to IDLE. Otherwise set col to (col+1), wrapping COLUMNAS-1 -> 0, and increment probes.
REQ-023 INSERTAR SHALL write jugador into the highest-index row of col holding 2'b00, load fila_out and col_out, pulse done, and return to IDLE, all in one edge.
REQ-024 Latency SHALL be fixed:
- first probed column free: done at E+2;
- k-th probed column free: done at E+k+1;
- board full: done at E+COLUMNAS.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start in the same cycle that done is high SHALL be accepted, because the state is already IDLE.
REQ-027 tablero_out, fila_out and col_out SHALL hold their values between operations.
REQ-028 lleno and err_jugador SHALL be 0 whenever done is 0.

Reset
REQ-029 While reset_n=0, and asynchronously on its falling edge:
- state = IDLE;
- lfsr = SEMILLA;
- tablero_out all 2'b00;
- done, busy, lleno, err_jugador, fila_out, col_out all 0.
REQ-030 A reset during BUSCAR or INSERTAR SHALL abort the operation with no partial write and no done pulse.

Structure
REQ-031 Package tablero_pkg SHALL hold the cell typedef (VACIO=2'b00, J1=2'b01, J2=2'b10), the state enum, and the LFSR tap constant.
REQ-032 The LFSR SHALL be a sub-module lfsr8 (clk, reset_n, semilla, q).
REQ-033 The lowest-free-row search SHALL be combinational inside insertor_aleatorio.

Verification
REQ-034 Empty board, modo=1, col_in=3, jugador=01 -> done at E+2; fila_out=5, col_out=3; tablero_out[5][3]=01.
REQ-035 Columns 3 and 4 full, modo=1, col_in=3, jugador=10 -> done at E+4; fila_out=5, col_out=5.
REQ-036 Full board, modo=0 -> done at E+7 with lleno=1; tablero_out equals tablero_in.
REQ-037 Column 6 has rows 1..5 filled, others full, modo=1, col_in=9 -> start column 2, wraps; done at E+6; fila_out=0, col_out=6.
REQ-038 jugador=11 -> done at E+1 with err_jugador=1; board unchanged. Then reset_n pulsed low mid-BUSCAR -> all outputs 0; no done pulse.
REQ-039 modo=0, start on the first cycle after reset release -> start column = 8'hA5 mod 7 = 4; done at E+2; col_out=4 on an empty board.
